// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit-scan serializer.
// Helpers work on a fixed wide vector; callers zero-extend their WIDTH-bit operand.
package bit_scan_pkg;

  // Upper bound on the WIDTH parameter supported by the helpers below.
  localparam int unsigned MaxWidth = 256;

  typedef enum logic [1:0] {StIdle, StScan, StZero} state_e;

  typedef logic [MaxWidth-1:0] wide_vec_t;

  function automatic int unsigned popcount(wide_vec_t v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

  // Index of the highest set bit, or the lowest when lsb_first is set; 0 for an empty vector.
  function automatic int unsigned find_first(wide_vec_t v, bit lsb_first);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (lsb_first) begin
        if (v[MaxWidth-1-i]) idx = MaxWidth - 1 - i;
      end else if (v[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational priority finder: index of the first set bit in scan order and
// a flag for exactly one bit set.
module prio_find
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          LsbFirst = 1'b0
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] index_o,
  output logic                     one_hot_single_o
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  wide_vec_t vec_ext;

  always_comb begin
    vec_ext                = '0;
    vec_ext[WIDTH-1:0]     = vec_i;
    index_o                = IdxW'(find_first(vec_ext, LsbFirst));
    one_hot_single_o       = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/bit_scan_serializer.sv
// Serializes the set-bit indices of an accepted vector, one per output beat.
// Define BIT_SCAN_LSB_FIRST_EN to scan lowest bit first instead of highest.
module bit_scan_serializer
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   out_index,
  output logic                       out_last,
  output logic                       out_zero,
  output logic [$clog2(WIDTH+1)-1:0] total_ones,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef BIT_SCAN_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_zero_q, out_zero_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] next_index;
  logic             next_single;
  wide_vec_t        in_ext;

  // Looks at the next remaining vector so the beat outputs can be registered.
  prio_find #(
    .WIDTH   (WIDTH),
    .LsbFirst(LsbFirst)
  ) u_prio_find (
    .vec_i           (rem_d),
    .index_o         (next_index),
    .one_hot_single_o(next_single)
  );

  always_comb begin
    state_d            = state_q;
    rem_d              = rem_q;
    total_d            = total_q;
    in_ext             = '0;
    in_ext[WIDTH-1:0]  = in_data;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          rem_d   = in_data;
          total_d = CNT_W'(popcount(in_ext));
          state_d = (in_data == '0) ? StZero : StScan;
        end
      end
      StScan: begin
        if (out_ready) begin
          rem_d = rem_q & ~(WIDTH'(1) << out_index_q);
          if (out_last_q) state_d = StIdle;
        end
      end
      StZero: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    in_ready_d  = (state_d == StIdle);
    busy_d      = !in_ready_d;
    out_valid_d = busy_d;
    out_zero_d  = (state_d == StZero);
    out_index_d = (state_d == StScan) ? next_index : '0;
    out_last_d  = out_zero_d || ((state_d == StScan) && next_single);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      total_q     <= '0;
      out_index_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      total_q     <= total_d;
      out_index_q <= out_index_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_zero_q  <= out_zero_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign out_zero   = out_zero_q;
  assign total_ones = total_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Self-checking bench for bit_scan_serializer (WIDTH=16) against a queue-based model.
module tb_bit_scan_serializer;

  localparam int unsigned W = 16;

`ifdef BIT_SCAN_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_index;
  logic         out_last;
  logic         out_zero;
  logic [4:0]   total_ones;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  bit_scan_serializer #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_zero  (out_zero),
    .total_ones(total_ones),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beat sequence: set-bit positions in scan order, or a single 0 for an empty vector.
  task automatic build_model(input logic [W-1:0] v);
    exp_q.delete();
    for (int i = 0; i < int'(W); i++) begin
      if (v[i]) begin
        if (LsbFirst) exp_q.push_back(i);
        else exp_q.push_front(i);
      end
    end
    if (v == '0) exp_q.push_back(0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 1);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_out_index"}, 32'(out_index), 0);
    check_eq({tag, "_out_last"}, 32'(out_last), 0);
    check_eq({tag, "_out_zero"}, 32'(out_zero), 0);
  endtask

  // mode 0: always ready, 1: toggle starting ready, 2: random ready.
  task automatic run_vector(input logic [W-1:0] vec, input int mode);
    int  guard;
    bit  phase;
    bit  r;
    int  ones;
    build_model(vec);
    ones  = $countones(vec);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("in_ready_pre", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = vec;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = W'($urandom);
    phase   = 1'b1;
    guard   = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      check_eq("beat_valid", 32'(out_valid), 1);
      check_eq("beat_index", 32'(out_index), 32'(exp_q[0]));
      check_eq("beat_last", 32'(out_last), 32'(exp_q.size() == 1));
      check_eq("beat_zero", 32'(out_zero), 32'(vec == '0));
      check_eq("beat_total", 32'(total_ones), 32'(ones));
      check_eq("beat_busy", 32'(busy), 1);
      check_eq("beat_in_ready", 32'(in_ready), 0);
      case (mode)
        0:       r = 1'b1;
        1:       begin r = phase; phase = ~phase; end
        default: r = 1'($urandom_range(1, 0));
      endcase
      out_ready = r;
      if (r) void'(exp_q.pop_front());
      if (exp_q.size() == 0) in_valid = 1'b0;
      @(negedge clk);
      in_data = W'($urandom);
      guard++;
    end
    check_eq("beats_drained", 32'(exp_q.size()), 0);
    in_valid  = 1'b0;
    out_ready = 1'($urandom_range(1, 0));
    check_idle("bubble");
    check_eq("bubble_total", 32'(total_ones), 32'(ones));
  endtask

  initial begin
    logic [W-1:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    out_ready = 1'b1;

    repeat (2) begin
      @(negedge clk);
      check_idle("reset");
      check_eq("reset_total", 32'(total_ones), 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run_vector(16'h0000, 0);
    run_vector(16'd2500, 0);
    run_vector(16'hFFFF, 1);
    run_vector(16'h8001, 0);
    run_vector(16'h0001, 1);

    // Reset in the middle of a scan, asserted together with a ready beat.
    in_valid  = 1'b1;
    in_data   = 16'hFFFF;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("mid_beat", 32'(out_index), LsbFirst ? 32'(k) : 32'(15 - k));
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    check_eq("mid_reset_total", 32'(total_ones), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_after");
    run_vector(16'h0020, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3, 0))
        0:       v = '0;
        1:       v = W'($urandom) & W'($urandom) & W'($urandom);
        default: v = W'($urandom);
      endcase
      run_vector(v, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_scan_serializer.md
Name: bit_scan_serializer

Overview:
- Parametrised, sequential successor to our combinational MSB encoder and multiple-ones detector.
- Accepts a WIDTH-bit vector over a valid/ready handshake.
- Emits the index of every set bit, one per output handshake, highest first, with a last flag and the total population count.
- Sits between a vector producer (status/request register) and a serial consumer (arbiter, interrupt dispatcher).

Parameters:
- WIDTH, 16, input vector width; legal values >= 2.
- IDX_W, $clog2(WIDTH), index width; derived localparam, not overridable.
- CNT_W, $clog2(WIDTH+1), population-count width; derived localparam.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  producer has a vector.
- in_ready  out  1  block can accept a vector.
- in_data  in  WIDTH  vector to scan.
- out_valid  out  1  out_index/out_last/out_zero are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_index  out  IDX_W  bit position of the current set bit.
- out_last  out  1  current beat is the final beat of this vector.
- out_zero  out  1  accepted vector was all zeros; single beat.
- total_ones  out  CNT_W  popcount of the accepted vector, held for the whole scan.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, remaining vector=0, in_ready=1, out_valid=0, out_index=0, out_last=0, out_zero=0, total_ones=0, busy=0.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch in_data into rem and latch popcount(in_data) into total_ones.
    - If in_data==0, go to ZERO; otherwise go to SCAN.
  - SCAN: out_valid=1; out_index=MSB index of rem; out_last=1 when rem has exactly one set bit.
    - On out_valid&&out_ready, clear bit out_index in rem.
    - If out_last was 1, go to IDLE; otherwise stay in SCAN.
  - ZERO: out_valid=1, out_zero=1, out_last=1, out_index=0. On out_ready, go to IDLE.
- Latency:
  - First beat is valid the cycle after input acceptance.
  - One beat per cycle while out_ready=1.
  - One idle bubble (in_ready=1) between vectors; no in/out overlap.
- Stall: while out_valid=1 and out_ready=0, all out_* outputs and total_ones hold stable. out_valid never drops without a handshake.
- in_data is ignored outside IDLE. in_valid may stay high; it is sampled only in IDLE.
- total_ones: range 0..WIDTH. Equals WIDTH for an all-ones input (e.g. 16 when WIDTH=16, hence CNT_W).
- out_index, out_last and out_zero are driven to 0 whenever out_valid=0.
- Reset mid-scan: on the next edge, return to IDLE and discard the remaining bits. No further beats are emitted.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
- Macro: BIT_SCAN_LSB_FIRST_EN.
- Defined: scan order is lowest set bit first. out_index = LSB index of rem. out_last is unchanged (exactly one bit remaining).
- Undefined: MSB-first order as specified above.
- Handshake, latency and total_ones are identical in both builds.

Decomposition:
- Package bit_scan_pkg:
  - state typedef enum {IDLE, SCAN, ZERO}.
  - function popcount.
  - function find_first(vector, lsb_first) returning the index.
- Sub-module prio_find (combinational, parameter WIDTH): vector in, index and one_hot_single flag out. Instantiated once.
- Remaining vector register and FSM live in bit_scan_serializer.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, total_ones=0, busy=0. No acceptance during reset.
- Zero vector: in_data=16'h0000 -> single beat out_zero=1, out_last=1, out_index=0, total_ones=0; then in_ready=1 next cycle.
- Sparse vector: in_data=16'd2500 (0x09C4), out_ready=1 -> indices 11, 8, 7, 6, 2 on consecutive cycles; out_last only on 2; total_ones=5.
- Backpressure: in_data=16'hFFFF, out_ready toggling 1/0 each cycle -> 16 beats, indices 15..0. Outputs stable on stalled cycles; total_ones=16.
- Mid-scan reset: 16'hFFFF, rst_n=0 after 3 beats (15, 14, 13) -> next cycle out_valid=0, in_ready=1. Then 16'h0020 -> single beat index 5, out_last=1.
- BIT_SCAN_LSB_FIRST_EN build: 16'd2500 -> 2, 6, 7, 8, 11, last on 11. 16'h8001 -> 0 then 15 (last).
